// File: rtl/shift_frame_if.sv
// Parallel-side bundle for the serial frame controller.
// Master is the producer/consumer; slave is the controller.
interface shift_frame_if #(
  parameter int WIDTH = 4
) ();
  logic             tx_valid_i;
  logic [WIDTH-1:0] tx_data_i;
  logic             tx_ready_o;
  logic             rx_valid_o;
  logic [WIDTH-1:0] rx_data_o;
  logic             rx_perr_o;

  modport master (
    output tx_valid_i,
    output tx_data_i,
    input  tx_ready_o,
    input  rx_valid_o,
    input  rx_data_o,
    input  rx_perr_o
  );

  modport slave (
    input  tx_valid_i,
    input  tx_data_i,
    output tx_ready_o,
    output rx_valid_o,
    output rx_data_o,
    output rx_perr_o
  );
endinterface

// File: rtl/shift_frame_ctrl.sv
// Serial frame sequencer: MSB-first shift out/in with an idle gap.
// Define PARITY_EN to append and check an even-parity bit per frame.
module shift_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  shift_frame_if.slave   bus,
  output logic           sd_o,
  output logic           sd_en_o,
  input  logic           sd_i,
  output logic           busy_o
);

`ifdef PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [GW-1:0]    gcnt, gcnt_d;
  logic [N-1:0]     tx_sh, tx_sh_d;
  logic [N-2:0]     rx_sh, rx_sh_d;
  logic             sd_d, sd_en_d;
  logic             rdy, rdy_d;
  logic             rv, rv_d;
  logic [WIDTH-1:0] rdat, rdat_d;
  logic             perr, perr_d;
  logic             busy, busy_d;

  logic [N-1:0]     frame;
  logic [N-1:0]     full;

`ifdef PARITY_EN
  assign frame = {bus.tx_data_i, ^bus.tx_data_i};
`else
  assign frame = bus.tx_data_i;
`endif
  // Word as it will look once the current sd_i bit is shifted in
  assign full = {rx_sh, sd_i};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      gcnt    <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      sd_o    <= 1'b0;
      sd_en_o <= 1'b0;
      rdy     <= 1'b1;
      rv      <= 1'b0;
      rdat    <= '0;
      perr    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      gcnt    <= gcnt_d;
      tx_sh   <= tx_sh_d;
      rx_sh   <= rx_sh_d;
      sd_o    <= sd_d;
      sd_en_o <= sd_en_d;
      rdy     <= rdy_d;
      rv      <= rv_d;
      rdat    <= rdat_d;
      perr    <= perr_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gcnt_d  = gcnt;
    tx_sh_d = tx_sh;
    rx_sh_d = rx_sh;
    sd_d    = 1'b0;
    sd_en_d = 1'b0;
    rdy_d   = rdy;
    rv_d    = 1'b0;
    rdat_d  = rdat;
    perr_d  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.tx_valid_i && rdy) begin
          tx_sh_d = frame;
          sd_d    = frame[N-1];
          sd_en_d = 1'b1;
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        rx_sh_d = full[N-2:0];
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          rv_d  = 1'b1;
`ifdef PARITY_EN
          rdat_d = full[N-1:1];
          perr_d = ^full;
`else
          rdat_d = full;
`endif
          if (GAP == 0) begin
            rdy_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            gcnt_d  = '0;
            state_d = S_GAP;
          end
        end else begin
          cnt_d   = cnt + 1'b1;
          tx_sh_d = tx_sh << 1;
          sd_d    = tx_sh[N-2];
          sd_en_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) begin
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt + 1'b1;
        end
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign bus.tx_ready_o = rdy;
  assign bus.rx_valid_o = rv;
  assign bus.rx_data_o  = rdat;
  assign bus.rx_perr_o  = perr;
  assign busy_o         = busy;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl: loopback DUT with GAP=1 and a GAP=0 DUT.
// Received words are checked against a queue of expected words.
module tb_shift_frame_ctrl;
`ifdef PARITY_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  typedef struct packed {
    logic [3:0] d;
    logic       p;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic inv = 1'b0;
  logic sd1_o, sd1_en, sd1_i, busy1;
  logic sd2_o, sd2_en, sd2_i, busy2;
  int   vecs = 0;
  int   errs = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;

  shift_frame_if #(.WIDTH(4)) b1 ();
  shift_frame_if #(.WIDTH(4)) b2 ();

  assign sd1_i = sd1_o ^ inv;
  assign sd2_i = sd2_o;

  shift_frame_ctrl #(.WIDTH(4), .GAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1),
    .sd_o(sd1_o), .sd_en_o(sd1_en), .sd_i(sd1_i), .busy_o(busy1)
  );

  shift_frame_ctrl #(.WIDTH(4), .GAP(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2),
    .sd_o(sd2_o), .sd_en_o(sd2_en), .sd_i(sd2_i), .busy_o(busy2)
  );

  always @(negedge clk) begin
    if (b1.rx_valid_o === 1'b1) begin
      vecs++;
      if (q1.size() == 0) begin
        errs++;
        $display("FAIL rx1_unexpected got=%h exp=none", b1.rx_data_o);
      end else begin
        e1 = q1.pop_front();
        if ({b1.rx_data_o, b1.rx_perr_o} !== e1) begin
          errs++;
          $display("FAIL rx1_word got=%h/%b exp=%h/%b",
                   b1.rx_data_o, b1.rx_perr_o, e1.d, e1.p);
        end
      end
    end
    if (b2.rx_valid_o === 1'b1) begin
      vecs++;
      if (q2.size() == 0) begin
        errs++;
        $display("FAIL rx2_unexpected got=%h exp=none", b2.rx_data_o);
      end else begin
        e2 = q2.pop_front();
        if ({b2.rx_data_o, b2.rx_perr_o} !== e2) begin
          errs++;
          $display("FAIL rx2_word got=%h/%b exp=%h/%b",
                   b2.rx_data_o, b2.rx_perr_o, e2.d, e2.p);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(logic [3:0] w, int i);
    if (i < 4) return w[3-i];
    return ^w;
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 40 && (q1.size() != 0 || q2.size() != 0); i++)
      tick();
    vecs++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout got=%0d/%0d exp=0/0", q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    b1.tx_valid_i = 1'b1;
    b1.tx_data_i  = 4'hA;
    b2.tx_valid_i = 1'b1;
    b2.tx_data_i  = 4'h5;
    tick();
    tick();
    vecs++;
    if ({b1.tx_ready_o, sd1_o, sd1_en, b1.rx_valid_o, b1.rx_data_o,
         b1.rx_perr_o, busy1} !== 10'b1_0_0_0_0000_0_0) begin
      errs++;
      $display("FAIL reset_dut1 got=%b%b%b%b%h%b%b exp=1000000000",
               b1.tx_ready_o, sd1_o, sd1_en, b1.rx_valid_o,
               b1.rx_data_o, b1.rx_perr_o, busy1);
    end
    vecs++;
    if ({b2.tx_ready_o, sd2_en, busy2, b2.rx_valid_o} !== 4'b1000) begin
      errs++;
      $display("FAIL reset_dut2 got=%b%b%b%b exp=1000",
               b2.tx_ready_o, sd2_en, busy2, b2.rx_valid_o);
    end
    b1.tx_valid_i = 1'b0;
    b2.tx_valid_i = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input logic [3:0] w, input int inv_idx);
    b1.tx_valid_i = 1'b1;
    b1.tx_data_i  = w;
    q1.push_back({w, 1'(inv_idx >= 0)});
    tick();
    b1.tx_valid_i = 1'b0;
    b1.tx_data_i  = 4'($urandom);
    for (int i = 0; i < N; i++) begin
      inv = (i == inv_idx);
      vecs++;
      if (sd1_en !== 1'b1 || sd1_o !== fbit(w, i) || b1.tx_ready_o !== 1'b0) begin
        errs++;
        $display("FAIL bit%0d_of_%h got=en%b/sd%b/rdy%b exp=en1/sd%b/rdy0",
                 i, w, sd1_en, sd1_o, b1.tx_ready_o, fbit(w, i));
      end
      tick();
    end
    inv = 1'b0;
    vecs++;
    if (b1.rx_valid_o !== 1'b1 || sd1_en !== 1'b0 || b1.tx_ready_o !== 1'b0) begin
      errs++;
      $display("FAIL done_cycle_%h got=v%b/en%b/rdy%b exp=v1/en0/rdy0",
               w, b1.rx_valid_o, sd1_en, b1.tx_ready_o);
    end
    tick();
    vecs++;
    if (b1.tx_ready_o !== 1'b1 || b1.rx_valid_o !== 1'b0 || b1.rx_data_o !== w) begin
      errs++;
      $display("FAIL gap_end_%h got=rdy%b/v%b/d%h exp=rdy1/v0/d%h",
               w, b1.tx_ready_o, b1.rx_valid_o, b1.rx_data_o, w);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    b1.tx_valid_i = 1'b1;
    b1.tx_data_i  = 4'h3;
    q1.push_back({4'h3, 1'b0});
    tick();
    b1.tx_data_i = 4'hF;
    for (int c = 1; c <= N + 1; c++) begin
      vecs++;
      if (b1.tx_ready_o !== 1'b0 || busy1 !== 1'b1) begin
        errs++;
        $display("FAIL b2b_busy_k+%0d got=rdy%b/busy%b exp=rdy0/busy1",
                 c, b1.tx_ready_o, busy1);
      end
      tick();
    end
    vecs++;
    if (b1.tx_ready_o !== 1'b1) begin
      errs++;
      $display("FAIL b2b_ready_k+%0d got=%b exp=1", N + 2, b1.tx_ready_o);
    end
    b1.tx_data_i = 4'hC;
    q1.push_back({4'hC, 1'b0});
    tick();
    b1.tx_valid_i = 1'b0;
    vecs++;
    if (busy1 !== 1'b1 || sd1_o !== 1'b1 || sd1_en !== 1'b1) begin
      errs++;
      $display("FAIL b2b_second_start got=busy%b/sd%b/en%b exp=1/1/1",
               busy1, sd1_o, sd1_en);
    end
    wait_drain();
  endtask

  task automatic test_gap0();
    b2.tx_valid_i = 1'b1;
    b2.tx_data_i  = 4'h6;
    for (int m = 0; m < 4; m++) q2.push_back({4'h6, 1'b0});
    tick();
    for (int c = 0; c < 3 * (N + 1); c++) begin
      vecs++;
      if (sd2_en !== ((c % (N + 1)) != N)) begin
        errs++;
        $display("FAIL gap0_en_c%0d got=%b exp=%b", c, sd2_en,
                 (c % (N + 1)) != N);
      end
      tick();
    end
    b2.tx_valid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_abort();
    b1.tx_valid_i = 1'b1;
    b1.tx_data_i  = 4'h5;
    tick();
    b1.tx_valid_i = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    vecs++;
    if ({busy1, b1.tx_ready_o, sd1_en, b1.rx_valid_o, b1.rx_data_o} !== 8'b0100_0000) begin
      errs++;
      $display("FAIL abort_state got=busy%b/rdy%b/en%b/v%b/d%h exp=0/1/0/0/0",
               busy1, b1.tx_ready_o, sd1_en, b1.rx_valid_o, b1.rx_data_o);
    end
    for (int c = 0; c < N + 3; c++) begin
      vecs++;
      if (b1.rx_valid_o !== 1'b0 || busy1 !== 1'b0) begin
        errs++;
        $display("FAIL abort_quiet_c%0d got=v%b/busy%b exp=0/0",
                 c, b1.rx_valid_o, busy1);
      end
      tick();
    end
    test_single(4'h9, -1);
  endtask

  initial begin
    b1.tx_valid_i = 1'b0;
    b1.tx_data_i  = 4'h0;
    b2.tx_valid_i = 1'b0;
    b2.tx_data_i  = 4'h0;
    test_reset();
    test_single(4'hA, -1);
    test_single(4'h6, -1);
    test_back_to_back();
    test_gap0();
    test_reset_abort();
`ifdef PARITY_EN
    test_single(4'h7, 4);
`endif
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
